regfile_sb: RTL and testbench

Integer register file with a pending-write scoreboard. It is the receiving end of the writeback port: it accepts `wen`/`waddr`/`wdata` from the writeback unit, and it serves two combinational read ports to decode. The scoreboard tracks destinations of in-flight long-latency producers (loads, CSR reads) and raises a decode stall until their writeback lands.

---
 rtl/rv_pkg.sv | 19 +
 rtl/reg_bypass_mux.sv | 45 ++++
 rtl/regfile_sb.sv | 111 +++++++++++
 tb/tb_regfile_sb.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RISC-V integer pipeline definitions.
// Provides the data width, register address width, the x0 address and the
// writeback source encodings used by the writeback unit.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    // Writeback source select, driven by the writeback unit.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_CSR = 2'd2,
        WB_PC4 = 2'd3
    } wb_src_t;

endpackage

// File: rtl/reg_bypass_mux.sv
// One read port of the register file.
// Selects x0 / same-cycle writeback bypass / stored value, and reports whether
// the source still waits on an outstanding long-latency producer.
// Ports:
//   rs_addr     - source register address
//   stored_data - regs[rs_addr] from storage
//   pending     - pending[rs_addr] from the scoreboard
//   wen/waddr/wdata - writeback port of this cycle
//   rs_data     - read data (combinational)
//   busy        - source has a pending producer not retiring this cycle
module reg_bypass_mux
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]   rs_addr,
    input  logic [XLEN-1:0] stored_data,
    input  logic            pending,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rs_data,
    output logic            busy
);

    logic is_zero;
    logic wb_hit;

    assign is_zero = (rs_addr == AW'(REG_ZERO));
    assign wb_hit  = wen && (waddr == rs_addr);

    always_comb begin
        rs_data = stored_data;
        if (is_zero) begin
            rs_data = '0;
        end else if (wb_hit) begin
            rs_data = wdata;
        end
    end

    // A retiring write is bypassed to the reader, so it no longer stalls.
    assign busy = pending && !wb_hit;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with pending-write scoreboard.
// Receives the writeback port, serves two combinational read ports to decode
// and raises a decode stall while a used source has an in-flight producer.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   wen, waddr, wdata      - writeback write port
//   rs1_addr/rs2_addr      - decode source addresses
//   rs1_used/rs2_used      - decoded instruction actually reads the source
//   rs1_data/rs2_data      - read data (combinational, write-first bypass)
//   sb_set, sb_addr        - mark destination of a long-latency producer
//   sb_flush               - clear all pending bits
//   rs1_busy/rs2_busy      - source waits on a pending producer
//   stall                  - decode must hold
module regfile_sb
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wen,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs1_used,
    input  logic            rs2_used,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_addr,
    input  logic            sb_flush,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] write_en;

    // Per-register write decode and scoreboard next state. Index 0 is tied
    // off so x0 is never written and never pending.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign write_en[gi]     = 1'b0;
            assign pending_next[gi] = 1'b0;
        end else begin : g_live
            logic set_hit;
            logic wb_hit;
            assign set_hit      = sb_set && (sb_addr == AW'(gi));
            assign wb_hit       = wen && (waddr == AW'(gi));
            assign write_en[gi] = wb_hit;
            // Flush wins, then a new producer beats a same-cycle retiring write.
            assign pending_next[gi] = sb_flush ? 1'b0 :
                                      set_hit  ? 1'b1 :
                                      wb_hit   ? 1'b0 :
                                                 pending[gi];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (write_en[i]) begin
                    regs[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    reg_bypass_mux #(.XLEN(XLEN), .AW(AW)) u_rs1 (
        .rs_addr     (rs1_addr),
        .stored_data (regs[rs1_addr]),
        .pending     (pending[rs1_addr]),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .rs_data     (rs1_data),
        .busy        (rs1_busy)
    );

    reg_bypass_mux #(.XLEN(XLEN), .AW(AW)) u_rs2 (
        .rs_addr     (rs2_addr),
        .stored_data (regs[rs2_addr]),
        .pending     (pending[rs2_addr]),
        .wen         (wen),
        .waddr       (waddr),
        .wdata       (wdata),
        .rs_data     (rs2_data),
        .busy        (rs2_busy)
    );

    assign stall = (rs1_busy && rs1_used) || (rs2_busy && rs2_used);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios followed by random
// traffic, all checked against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        sb_flush;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    regfile_sb #(.XLEN(32), .NREG(32), .AW(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wen      (wen),
        .waddr    (waddr),
        .wdata    (wdata),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .sb_flush (sb_flush),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wen && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        return m_pend[a] && !(wen && waddr == a);
    endfunction

    function automatic logic m_stall();
        return (m_busy(rs1_addr) && rs1_used) || (m_busy(rs2_addr) && rs2_used);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Applies the effect of one rising edge with the current inputs.
    task automatic model_edge();
        bit [31:0] nxt;
        for (int i = 1; i < 32; i++) begin
            if (sb_flush) m_pend[i] = 1'b0;
            else if (sb_set && sb_addr == 5'(i)) m_pend[i] = 1'b1;
            else if (wen && waddr == 5'(i)) m_pend[i] = 1'b0;
        end
        if (wen && waddr != 5'd0) m_regs[waddr] = wdata;
        nxt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rs1_data"}, rs1_data, m_data(rs1_addr));
        check({tag, ".rs2_data"}, rs2_data, m_data(rs2_addr));
        check({tag, ".rs1_busy"}, 32'(rs1_busy), 32'(m_busy(rs1_addr)));
        check({tag, ".rs2_busy"}, 32'(rs2_busy), 32'(m_busy(rs2_addr)));
        check({tag, ".stall"},    32'(stall),    32'(m_stall()));
    endtask

    task automatic idle();
        wen = 0; waddr = 0; wdata = 0;
        rs1_addr = 0; rs2_addr = 0; rs1_used = 0; rs2_used = 0;
        sb_set = 0; sb_addr = 0; sb_flush = 0;
    endtask

    // Inputs are already driven; settle, compare, clock, update model.
    task automatic cycle(input string tag);
        #1;
        n_txn++;
        $display("txn %0d %s: wen=%0b wa=%0d wd=%08h rs1=%0d rs2=%0d set=%0b sa=%0d fl=%0b -> d1=%08h d2=%08h b1=%0b b2=%0b st=%0b",
                 n_txn, tag, wen, waddr, wdata, rs1_addr, rs2_addr, sb_set, sb_addr,
                 sb_flush, rs1_data, rs2_data, rs1_busy, rs2_busy, stall);
        check_all(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset state
        idle(); rs1_addr = 1; rs2_addr = 31; rs1_used = 1; rs2_used = 1;
        #1;
        check("reset.x1", rs1_data, 32'd0);
        check("reset.x31", rs2_data, 32'd0);
        check("reset.stall", 32'(stall), 32'd0);
        cycle("reset");

        // Mid-run asynchronous reset discards a write
        idle(); wen = 1; waddr = 5; wdata = 32'hDEADBEEF;
        cycle("wr_x5");
        idle(); rs1_addr = 5;
        #1;
        check("x5_before_rst", rs1_data, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("x5_in_rst", rs1_data, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cycle("after_rst");

        // x0 writes dropped, x0 never pending
        idle(); wen = 1; waddr = 0; wdata = 32'h12345678;
        cycle("wr_x0");
        idle(); rs1_addr = 0; rs1_used = 1; sb_set = 1; sb_addr = 0;
        #1;
        check("x0_read", rs1_data, 32'd0);
        cycle("set_x0");
        idle(); rs1_addr = 0; rs1_used = 1;
        #1;
        check("x0_stall", 32'(stall), 32'd0);
        cycle("x0_chk");

        // Same-cycle bypass, then storage
        idle(); wen = 1; waddr = 7; wdata = 32'hA5A5A5A5; rs1_addr = 7;
        #1;
        check("bypass_x7", rs1_data, 32'hA5A5A5A5);
        cycle("byp_x7");
        idle(); rs1_addr = 7; rs2_addr = 7;
        #1;
        check("stored_x7", rs1_data, 32'hA5A5A5A5);
        check("same_addr", rs2_data, rs1_data);
        cycle("st_x7");

        // Scoreboard stall on x3 and clearing writeback
        idle(); sb_set = 1; sb_addr = 3;
        cycle("set_x3");
        idle(); rs2_addr = 3; rs2_used = 1;
        #1;
        check("x3_stall", 32'(stall), 32'd1);
        cycle("x3_used");
        idle(); rs2_addr = 3; rs2_used = 0;
        #1;
        check("x3_unused", 32'(stall), 32'd0);
        cycle("x3_unused");
        idle(); rs2_addr = 3; rs2_used = 1; wen = 1; waddr = 3; wdata = 32'h55;
        #1;
        check("x3_wb_stall", 32'(stall), 32'd0);
        check("x3_wb_data", rs2_data, 32'h55);
        cycle("x3_wb");
        idle(); rs2_addr = 3; rs2_used = 1;
        #1;
        check("x3_cleared", 32'(rs2_busy), 32'd0);
        cycle("x3_after");

        // Set beats same-cycle write; flush clears
        idle(); sb_set = 1; sb_addr = 4; wen = 1; waddr = 4; wdata = 32'h1;
        cycle("set_wr_x4");
        idle(); rs1_addr = 4; rs1_used = 1;
        #1;
        check("x4_data", rs1_data, 32'h1);
        check("x4_busy", 32'(rs1_busy), 32'd1);
        cycle("x4_chk");
        idle(); sb_flush = 1;
        cycle("flush");
        idle(); rs1_addr = 4;
        #1;
        check("x4_flushed", 32'(rs1_busy), 32'd0);
        cycle("x4_after");

        // Flush beats same-cycle set
        idle(); sb_flush = 1; sb_set = 1; sb_addr = 9;
        cycle("flush_set_x9");
        idle(); rs1_addr = 9;
        #1;
        check("x9_busy", 32'(rs1_busy), 32'd0);
        cycle("x9_after");

        // Random traffic, addresses biased to a small window for collisions
        for (int n = 0; n < 400; n++) begin
            idle();
            wen      = ($urandom_range(0, 99) < 45);
            waddr    = 5'($urandom_range(0, 7));
            wdata    = $urandom;
            rs1_addr = (n % 16 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            rs2_addr = 5'($urandom_range(0, 7));
            rs1_used = $urandom_range(0, 1);
            rs2_used = $urandom_range(0, 1);
            sb_flush = ($urandom_range(0, 99) < 4);
            sb_addr  = 5'($urandom_range(0, 7));
            #1;
            // Caller never issues a producer while decode is stalled.
            sb_set   = ($urandom_range(0, 99) < 30) && !m_stall();
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
